// File: rtl/ff_scandoubler.sv
// 15 kHz -> 31 kHz line doubler: each input line is captured into one half of a
// ping-pong line RAM while the previous line is replayed twice at the full clock rate.
module ff_scandoubler #(
    parameter int ADDR_W   = 9,
    parameter int HS_WIDTH = 46
) (
    input  logic       clk12m,
    input  logic       reset_n,
    input  logic       pix_ce,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic [7:0] rgb_in,
    output logic       hsync_out,
    output logic       vsync_out,
    output logic       blank_out,
    output logic [7:0] rgb_out,
    output logic       ovf
);

    localparam logic [ADDR_W-1:0] HCNT_MAX = '1;
    localparam logic [ADDR_W-1:0] HSW      = ADDR_W'(HS_WIDTH);

    typedef enum logic [1:0] {IDLE, COPY0, COPY1} state_t;

    logic              hs_prev_q, wsel_q, rd_sel_q, valid_q, ovf_q;
    logic              vs_cap_q, vs_line_q;
    logic [ADDR_W-1:0] hcnt_in_q, len_cap_q;
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] hcnt_out_q, hcnt_out_d;
    logic              hsync_q, vsync_q, blank_q;
    logic [7:0]        rd_data_q;
    logic [7:0]        mem_q [2**(ADDR_W+1)];

    logic              ls, we, last;
    logic [ADDR_W:0]   waddr;

    assign ls = pix_ce & ~hsync_in & hs_prev_q;

    // Capture side: LS switches halves and starts the new line at address 0.
    always_comb begin
        we    = 1'b0;
        waddr = {wsel_q, hcnt_in_q};
        if (pix_ce) begin
            if (ls) begin
                we    = 1'b1;
                waddr = {~wsel_q, {ADDR_W{1'b0}}};
            end else begin
                we    = (hcnt_in_q != HCNT_MAX);
            end
        end
    end

    always_ff @(posedge clk12m or negedge reset_n) begin
        if (!reset_n) begin
            hs_prev_q <= 1'b1;
            wsel_q    <= 1'b0;
            rd_sel_q  <= 1'b0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
            vs_cap_q  <= 1'b1;
            vs_line_q <= 1'b1;
            hcnt_in_q <= '0;
            len_cap_q <= '0;
        end else if (pix_ce) begin
            hs_prev_q <= hsync_in;
            if (ls) begin
                len_cap_q <= hcnt_in_q;
                rd_sel_q  <= wsel_q;
                wsel_q    <= ~wsel_q;
                hcnt_in_q <= ADDR_W'(1);
                vs_cap_q  <= vsync_in;
                vs_line_q <= vs_cap_q;
                valid_q   <= 1'b1;
            end else if (hcnt_in_q == HCNT_MAX) begin
                ovf_q     <= 1'b1;
            end else begin
                hcnt_in_q <= hcnt_in_q + ADDR_W'(1);
            end
        end
    end

    // Replay FSM: LS always wins over the end-of-copy wrap.
    assign last = (hcnt_out_q == len_cap_q - ADDR_W'(1));

    always_comb begin
        state_d    = state_q;
        hcnt_out_d = hcnt_out_q;
        if (ls) begin
            hcnt_out_d = '0;
            state_d    = (valid_q && hcnt_in_q != '0) ? COPY0 : IDLE;
        end else begin
            case (state_q)
                COPY0: begin
                    if (last) begin
                        hcnt_out_d = '0;
                        state_d    = COPY1;
                    end else begin
                        hcnt_out_d = hcnt_out_q + ADDR_W'(1);
                    end
                end
                COPY1: begin
                    if (last) begin
                        hcnt_out_d = '0;
                        state_d    = IDLE;
                    end else begin
                        hcnt_out_d = hcnt_out_q + ADDR_W'(1);
                    end
                end
                default: begin
                    state_d    = IDLE;
                    hcnt_out_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk12m or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            hcnt_out_q <= '0;
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
            blank_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            hcnt_out_q <= hcnt_out_d;
            hsync_q    <= ~((state_q != IDLE) && (hcnt_out_q < HSW));
            blank_q    <= (state_q == IDLE) || (hcnt_out_q < HSW);
            vsync_q    <= (state_q != IDLE) ? vs_line_q : 1'b1;
        end
    end

    // Line RAM; read data lines up with the registered sync/blank outputs.
    always_ff @(posedge clk12m) begin
        if (we) mem_q[waddr] <= rgb_in;
        rd_data_q <= mem_q[{rd_sel_q, hcnt_out_q}];
    end

    assign hsync_out = hsync_q;
    assign vsync_out = vsync_q;
    assign blank_out = blank_q;
    assign rgb_out   = blank_q ? 8'd0 : rd_data_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_ff_scandoubler.sv
// Directed bench for ff_scandoubler: drives whole input lines, logs the outputs every
// cycle, then checks each logged output line against a replay model of the previous line.
module tb_ff_scandoubler;

    localparam int LOGN  = 32768;
    localparam int MAXPX = 511;
    localparam int HSW   = 46;

    logic       clk12m = 1'b0;
    logic       reset_n, pix_ce, hsync_in, vsync_in;
    logic [7:0] rgb_in;
    logic       hsync_out, vsync_out, blank_out, ovf;
    logic [7:0] rgb_out;

    ff_scandoubler dut (
        .clk12m(clk12m), .reset_n(reset_n), .pix_ce(pix_ce), .hsync_in(hsync_in),
        .vsync_in(vsync_in), .rgb_in(rgb_in), .hsync_out(hsync_out),
        .vsync_out(vsync_out), .blank_out(blank_out), .rgb_out(rgb_out), .ovf(ovf)
    );

    always #5 clk12m = ~clk12m;

    int   cyc = 0;
    logic hs_log [LOGN];
    logic vs_log [LOGN];
    logic bl_log [LOGN];
    logic ov_log [LOGN];
    logic [7:0] rgb_log [LOGN];

    always @(posedge clk12m) cyc <= cyc + 1;

    always @(negedge clk12m) begin
        if (cyc < LOGN) begin
            hs_log[cyc]  <= hsync_out;
            vs_log[cyc]  <= vsync_out;
            bl_log[cyc]  <= blank_out;
            ov_log[cyc]  <= ovf;
            rgb_log[cyc] <= rgb_out;
        end
    end

    int tot = 0;
    int bad = 0;
    int nl  = 0;
    int ls_e [32];
    int ln_len [32];
    bit ln_vs [32];
    bit ln_first [32];
    int ln_stop [32];
    bit first_flag;

    task automatic chk(input string tag, input int t, input logic [7:0] got, input logic [7:0] exp);
        tot++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s t=%0d got=%0h exp=%0h", tag, t, got, exp);
        end
    endtask

    // Driver steps start 1 time unit after a falling edge; pix_ce is sampled on the next rising edge.
    task automatic drive_px(input logic hs, input logic vs, input logic [7:0] px);
        pix_ce = 1'b1; hsync_in = hs; vsync_in = vs; rgb_in = px;
        @(negedge clk12m); #1;
        pix_ce = 1'b0;
        @(negedge clk12m); #1;
    endtask

    task automatic send_line(input int len, input bit vs);
        ls_e[nl]     = cyc + 1;
        ln_len[nl]   = len;
        ln_vs[nl]    = vs;
        ln_first[nl] = first_flag;
        ln_stop[nl]  = 0;
        first_flag   = 1'b0;
        nl++;
        for (int i = 0; i < len; i++) begin
            logic [31:0] iv;
            iv = i;
            drive_px((i == 0) ? 1'b0 : 1'b1, vs, iv[7:0]);
        end
    endtask

    task automatic check_range(input int t0, input int t1, input int len, input bit vs);
        for (int t = t0; t <= t1; t++) begin
            int idx, j;
            logic e_hs, e_bl, e_vs;
            logic [7:0] e_rgb;
            logic [31:0] jv;
            idx = t - t0;
            e_hs = 1'b1; e_bl = 1'b1; e_vs = 1'b1; e_rgb = 8'd0;
            if (idx < 2 * len) begin
                j     = idx % len;
                jv    = j;
                e_hs  = (j < HSW) ? 1'b0 : 1'b1;
                e_bl  = (j < HSW);
                e_rgb = e_bl ? 8'd0 : jv[7:0];
                e_vs  = vs;
            end
            chk("hsync", t, {7'd0, hs_log[t]}, {7'd0, e_hs});
            chk("blank", t, {7'd0, bl_log[t]}, {7'd0, e_bl});
            chk("vsync", t, {7'd0, vs_log[t]}, {7'd0, e_vs});
            chk("rgb",   t, rgb_log[t], e_rgb);
        end
    endtask

    task automatic check_line(input int n);
        int t0, t1, len;
        bit vs;
        t0  = ls_e[n] + 1;
        t1  = (ln_stop[n] != 0) ? ln_stop[n] : ls_e[n+1];
        len = 0;
        vs  = 1'b1;
        if (!ln_first[n]) begin
            len = (ln_len[n-1] > MAXPX) ? MAXPX : ln_len[n-1];
            vs  = ln_vs[n-1];
        end
        check_range(t0, t1, len, vs);
    endtask

    int rst_t, q0, fin;

    initial begin
        reset_n = 1'b0; pix_ce = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1; rgb_in = 8'd0;
        repeat (3) @(negedge clk12m);
        #1;
        chk("rst_hsync", cyc, {7'd0, hsync_out}, 8'd1);
        chk("rst_vsync", cyc, {7'd0, vsync_out}, 8'd1);
        chk("rst_blank", cyc, {7'd0, blank_out}, 8'd1);
        chk("rst_rgb",   cyc, rgb_out, 8'd0);
        chk("rst_ovf",   cyc, {7'd0, ovf}, 8'd0);
        reset_n = 1'b1;
        @(negedge clk12m); #1;
        first_flag = 1'b1;

        // Overflowing line, a normal line, then reset part-way through the third.
        send_line(600, 1'b1);
        send_line(384, 1'b1);
        send_line(100, 1'b1);
        rst_t = cyc;
        ln_stop[nl-1] = rst_t;
        chk("pre_rst_ovf",   rst_t, {7'd0, ovf}, 8'd1);
        chk("pre_rst_blank", rst_t, {7'd0, blank_out}, 8'd0);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_hsync", cyc, {7'd0, hsync_out}, 8'd1);
        chk("mid_rst_vsync", cyc, {7'd0, vsync_out}, 8'd1);
        chk("mid_rst_blank", cyc, {7'd0, blank_out}, 8'd1);
        chk("mid_rst_rgb",   cyc, rgb_out, 8'd0);
        chk("mid_rst_ovf",   cyc, {7'd0, ovf}, 8'd0);
        repeat (3) @(negedge clk12m);
        #1;
        reset_n = 1'b1;
        first_flag = 1'b1;
        for (int i = 0; i < 50; i++) drive_px(1'b1, 1'b1, 8'hA5);

        // Steady lines with vsync low on lines 3..5, then short, overflow and tiny lines.
        q0 = nl;
        for (int k = 0; k < 9; k++) send_line(384, !(k >= 3 && k <= 5));
        send_line(200, 1'b1);
        send_line(600, 1'b1);
        send_line(600, 1'b1);
        send_line(2, 1'b1);
        send_line(2, 1'b1);
        send_line(384, 1'b1);
        send_line(384, 1'b1);
        send_line(384, 1'b1);
        for (int i = 0; i < 800; i++) drive_px(1'b1, 1'b1, 8'h00);
        fin = cyc;
        ln_stop[nl-1] = fin;

        chk("ovf_pre_q10", ls_e[q0+10], {7'd0, ov_log[ls_e[q0+10]]}, 8'd0);
        chk("ovf_px510",   ls_e[q0+10] + 1021, {7'd0, ov_log[ls_e[q0+10] + 1021]}, 8'd0);
        chk("ovf_px511",   ls_e[q0+10] + 1022, {7'd0, ov_log[ls_e[q0+10] + 1022]}, 8'd1);
        chk("ovf_q11",     ls_e[q0+11], {7'd0, ov_log[ls_e[q0+11]]}, 8'd1);
        chk("ovf_end",     fin, {7'd0, ovf}, 8'd1);

        check_range(rst_t + 1, ls_e[q0], 0, 1'b1);
        for (int n = 0; n < nl; n++) check_line(n);

        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
